ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 command transmitter: sends one byte (e.g. 0xED LED-set, 0xFF reset) to the keyboard.
//  Sits beside the PS/2 receiver that feeds the piano's ps2_received path; it drives the open-drain PS/2 clock and data lines.
//  It accepts a byte by valid/ready, runs the inhibit/start/shift/ack sequence and reports done with an error code.
//  tx_busy tells the receiver to discard frames while a command is in flight.
// PARAMETERS
//  INHIBIT_CYC  6000    cycles PS/2 clock is held low before the start bit (120 us at 50 MHz)
//  START_CYC    250     cycles data is held low with clock still low before clock release (5 us)
//  TIMEOUT_CYC  750000  max cycles between device clock falling edges, and for the final idle wait (15 ms)
// PORTS
//  clock       in   1  system clock; all logic is on its rising edge
//  resetn      in   1  asynchronous, active-low reset
//  cmd_data    in   8  byte to transmit
//  cmd_valid   in   1  cmd_data is valid
//  cmd_ready   out  1  block is in IDLE and can accept a byte
//  ps2_clk_in  in   1  raw PS/2 clock pin level (asynchronous)
//  ps2_dat_in  in   1  raw PS/2 data pin level (asynchronous)
//  ps2_clk_oe  out  1  1 = pull the PS/2 clock low; 0 = release it
//  ps2_dat_oe  out  1  1 = pull the PS/2 data line low; 0 = release it
//  tx_busy     out  1  high in every state except IDLE
//  done        out  1  one-cycle pulse when the transaction ends
//  err_code    out  2  valid with done: 00 ok, 01 timeout, 10 no ack
// BEHAVIOUR
//  Reset:
//  - All outputs reset to 0 except cmd_ready, which resets to 1; state resets to IDLE.
//  - Asserting resetn low mid-transaction releases both lines at once and drops the command.
//  Input sync and edge detect:
//  - ps2_clk_in and ps2_dat_in each pass through a 2-flop synchroniser.
//  - fall = sync_clk_prev & ~sync_clk, counted only in SHIFT and ACK.
//  Accept:
//  - A byte is taken on the cycle where cmd_valid & cmd_ready; it latches cmd_data and par = ~^cmd_data (odd parity).
//  - The next state is INHIBIT; cmd_valid is ignored whenever cmd_ready = 0.
//  States:
//  - IDLE: both oe = 0, cmd_ready = 1.
//  - INHIBIT: clk_oe = 1, dat_oe = 0 for exactly INHIBIT_CYC cycles, then START.
//  - START: clk_oe = 1, dat_oe = 1 (start bit 0) for START_CYC cycles, then SHIFT with clk_oe = 0, bit index k = 0, timeout counter cleared.
//  - SHIFT, on each fall:
//    - k = 0..7: dat_oe <= ~byte[k] (LSB first).
//    - k = 8: dat_oe <= ~par.
//    - k = 9: dat_oe <= 0 (stop bit; line released); go to ACK.
//  - ACK: on the next fall, sample sync_dat; 0 goes to WAIT_IDLE, 1 ends with err 10.
//  - WAIT_IDLE: wait for sync_clk = 1 and sync_dat = 1, then done = 1 with err_code = 00, and go to IDLE.
//  Timing and timeout:
//  - dat_oe updates no later than 3 clock cycles after the pin's falling edge.
//  - Data therefore changes while the device clock is low.
//  - The timeout counter clears on every fall and on entry to SHIFT. In SHIFT, ACK and WAIT_IDLE, reaching TIMEOUT_CYC ends with err 01.
//  Termination (error exit or normal completion):
//  - Both oe <= 0 and done pulses for 1 cycle with err_code set.
//  - The state returns to IDLE, and cmd_ready is 1 on the following cycle.
//  - err_code holds its value until the next accept.
//  Edge and width rules:
//  - A pin falling while the block itself drives clock low (INHIBIT, START) is not a fall.
//  - The rising edge caused by clock release is not counted.
//  - Counter widths are $clog2 of each parameter plus 1.
//  - k is 4 bits and never exceeds 10.
// TESTING
//  1. Send 0xED with an acking device BFM (10 kHz clock) -> clk held low 6000 cycles; data line reads 0,1,0,1,1,0,1,1,1 (start, LSB first), parity 1, stop 1; done with err 00.
//  2. Send 0x01 -> parity bit 0 on the line. Send 0xFF -> parity bit 1. Device sees correct odd parity both times.
//  3. BFM leaves data high at the 11th falling edge -> done with err_code 10; both oe = 0; cmd_ready = 1 one cycle later.
//  4. BFM never clocks -> done with err 01 exactly 6000 + 250 + 750000 cycles after accept; lines released.
//  5. resetn low after the 4th falling edge -> both oe = 0 and tx_busy = 0 immediately; after release, cmd_ready = 1 and the next byte (0xF4) goes out cleanly.
//  6. Hold cmd_valid = 1 with 0xAA during busy, then 0x55 back-to-back -> 0xAA is not re-accepted until done; exactly two frames sent in order.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, start, 8 data bits LSB first, odd parity, stop, then device ack.
// One command in flight: cmd_ready is low from accept until done; dat_oe follows a device clock fall within 3 cycles.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 6000,
  parameter int START_CYC   = 250,
  parameter int TIMEOUT_CYC = 750000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_busy,
  output logic       done,
  output logic [1:0] err_code
);

  localparam int MAX_A   = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
  localparam int MAX_CYC = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYC - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_CYC - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_TO   = 2'b01;
  localparam logic [1:0] ERR_NACK = 2'b10;

  typedef enum logic [2:0] {IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE} state_t;

  state_t        state;
  logic [7:0]    byte_r;
  logic          par;
  logic [CW-1:0] cnt;
  logic [3:0]    k;

  logic clk_meta, sync_clk, sync_clk_prev;
  logic dat_meta, sync_dat;
  logic fall, timeout, end_req;
  logic [1:0] end_code;

  // Idle-high reset values keep the edge detector quiet coming out of reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_meta      <= 1'b1;
      sync_clk      <= 1'b1;
      sync_clk_prev <= 1'b1;
      dat_meta      <= 1'b1;
      sync_dat      <= 1'b1;
    end else begin
      clk_meta      <= ps2_clk_in;
      sync_clk      <= clk_meta;
      sync_clk_prev <= sync_clk;
      dat_meta      <= ps2_dat_in;
      sync_dat      <= dat_meta;
    end
  end

  assign fall    = sync_clk_prev & ~sync_clk;
  assign timeout = (cnt == TO_LAST);

  always_comb begin
    end_req  = 1'b0;
    end_code = ERR_OK;
    case (state)
      SHIFT: if (!fall && timeout) begin
        end_req  = 1'b1;
        end_code = ERR_TO;
      end
      ACK: begin
        if (fall && sync_dat) begin
          end_req  = 1'b1;
          end_code = ERR_NACK;
        end else if (!fall && timeout) begin
          end_req  = 1'b1;
          end_code = ERR_TO;
        end
      end
      WAIT_IDLE: begin
        if (sync_clk && sync_dat) begin
          end_req  = 1'b1;
          end_code = ERR_OK;
        end else if (timeout) begin
          end_req  = 1'b1;
          end_code = ERR_TO;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_busy    <= 1'b0;
      done       <= 1'b0;
      err_code   <= ERR_OK;
      byte_r     <= '0;
      par        <= 1'b0;
      cnt        <= '0;
      k          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (cmd_valid && cmd_ready) begin
          byte_r     <= cmd_data;
          par        <= ~^cmd_data;
          err_code   <= ERR_OK;
          cmd_ready  <= 1'b0;
          tx_busy    <= 1'b1;
          ps2_clk_oe <= 1'b1;
          ps2_dat_oe <= 1'b0;
          cnt        <= '0;
          state      <= INHIBIT;
        end
        INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt        <= '0;
            ps2_dat_oe <= 1'b1;
            state      <= START;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        START: begin
          if (cnt == START_LAST) begin
            cnt        <= '0;
            k          <= '0;
            ps2_clk_oe <= 1'b0;
            state      <= SHIFT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SHIFT: begin
          if (fall) begin
            cnt <= '0;
            k   <= k + 4'd1;
            if (k < 4'd8) begin
              ps2_dat_oe <= ~byte_r[k[2:0]];
            end else if (k == 4'd8) begin
              ps2_dat_oe <= ~par;
            end else begin
              ps2_dat_oe <= 1'b0;
              state      <= ACK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ACK: begin
          if (fall) begin
            cnt   <= '0;
            state <= WAIT_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IDLE: cnt <= cnt + CW'(1);
        default:   state <= IDLE;
      endcase
      // Every exit path shares one release-and-report sequence.
      if (end_req) begin
        state      <= IDLE;
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
        done       <= 1'b1;
        err_code   <= end_code;
        cmd_ready  <= 1'b1;
        tx_busy    <= 1'b0;
      end
    end
  end

endmodule
